// File: rtl/uart_arb_pkg.sv
// Shared state encoding and default sizing for the two-requester UART TX arbiter.
package uart_arb_pkg;

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_e;

  localparam int DEF_NUM_BITS     = 8;
  localparam int DEF_MAX_PKT_LEN  = 256;
  localparam int DEF_IDLE_TIMEOUT = 1024;

endpackage

// File: rtl/uart_tx_arbiter_slot.sv
// Single-entry registered output slot toward the UART transmitter.
module uart_byte_slot
  import uart_arb_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BITS-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_BITS-1:0] tx_data,
  output logic                tx_data_valid,
  input  logic                tx_data_ready
);

  logic [NUM_BITS-1:0] tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;

  // A new byte may enter when the slot is empty or is being drained this cycle.
  assign in_ready = !tx_valid_q || tx_data_ready;

  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (in_valid && in_ready) begin
      tx_data_d  = in_data;
      tx_valid_d = 1'b1;
    end else if (tx_data_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter feeding one UART transmitter; ownership ends on
// last byte, packet length limit or idle timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_BITS     = DEF_NUM_BITS,
  parameter int MAX_PKT_LEN  = DEF_MAX_PKT_LEN,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BITS-1:0] req0_data,
  input  logic                req0_valid,
  input  logic                req0_last,
  output logic                req0_ready,
  input  logic [NUM_BITS-1:0] req1_data,
  input  logic                req1_valid,
  input  logic                req1_last,
  output logic                req1_ready,
  output logic [NUM_BITS-1:0] tx_data,
  output logic                tx_data_valid,
  input  logic                tx_data_ready,
  output logic [1:0]          grant,
  output logic                timeout_evt
);

  localparam int CNT_W  = $clog2(MAX_PKT_LEN) + 1;
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT) + 1;

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              last_winner_q, last_winner_d;
  logic              timeout_evt_q, timeout_evt_d;

  logic                own0, own1, slot_ready, sel_valid, sel_last, accept;
  logic                pkt_done, timeout_hit;
  logic [NUM_BITS-1:0] sel_data;

  assign own0      = (state_q == ST_OWN0);
  assign own1      = (state_q == ST_OWN1);
  assign sel_valid = (own0 && req0_valid) || (own1 && req1_valid);
  assign sel_last  = own0 ? req0_last : req1_last;
  assign sel_data  = own0 ? req0_data : req1_data;
  assign accept    = sel_valid && slot_ready;

  assign pkt_done    = accept && (sel_last || ((byte_cnt_q + CNT_W'(1)) == CNT_W'(MAX_PKT_LEN)));
  // Timeout is evaluated independently of acceptance so it can coincide with a last-byte release.
  assign timeout_hit = (own0 || own1) && (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1));

  uart_byte_slot #(.NUM_BITS(NUM_BITS)) u_slot (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_data       (sel_data),
    .in_valid      (sel_valid),
    .in_ready      (slot_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready)
  );

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    last_winner_d = last_winner_q;
    timeout_evt_d = 1'b0;
    case (state_q)
      ST_OWN0, ST_OWN1: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
        timeout_evt_d = timeout_hit;
        if (pkt_done || timeout_hit) begin
          state_d       = ST_IDLE;
          byte_cnt_d    = '0;
          idle_cnt_d    = '0;
          last_winner_d = own1;
        end
      end
      default: begin
        byte_cnt_d = '0;
        idle_cnt_d = '0;
        if (req0_valid && req1_valid) begin
          state_d = last_winner_q ? ST_OWN0 : ST_OWN1;
        end else if (req0_valid) begin
          state_d = ST_OWN0;
        end else if (req1_valid) begin
          state_d = ST_OWN1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      last_winner_q <= 1'b1;
      timeout_evt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      last_winner_q <= last_winner_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign req0_ready  = own0 && slot_ready;
  assign req1_ready  = own1 && slot_ready;
  assign grant       = state_q;
  assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner sequences and random traffic vs. a reference model.
module tb_uart_tx_arbiter;

  localparam int NB   = 8;
  localparam int MAXP = 256;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] req0_data, req1_data, tx_data;
  logic          req0_valid, req1_valid, req0_last, req1_last;
  logic          req0_ready, req1_ready;
  logic          tx_data_valid, tx_data_ready, timeout_evt;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_BITS(NB), .MAX_PKT_LEN(MAXP), .IDLE_TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req0_data     (req0_data),
    .req0_valid    (req0_valid),
    .req0_last     (req0_last),
    .req0_ready    (req0_ready),
    .req1_data     (req1_data),
    .req1_valid    (req1_valid),
    .req1_last     (req1_last),
    .req1_ready    (req1_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .grant         (grant),
    .timeout_evt   (timeout_evt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: owner is -1 when idle, else the requester index; the output slot is one pending byte.
  typedef struct {
    int         owner;
    int         lastw;
    int         cnt;
    int         idle;
    bit         pv;
    logic [7:0] pd;
    bit         tevt;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t m_reset();
    mstate_t r;
    r.owner = -1; r.lastw = 1; r.cnt = 0; r.idle = 0;
    r.pv = 1'b0; r.pd = 8'h00; r.tevt = 1'b0;
    return r;
  endfunction

  function automatic mstate_t m_next(mstate_t s);
    mstate_t n = s;
    bit a0, a1, tmo, done;
    a0 = (s.owner == 0) && (!s.pv || tx_data_ready) && req0_valid;
    a1 = (s.owner == 1) && (!s.pv || tx_data_ready) && req1_valid;
    n.tevt = 1'b0;
    if (s.owner < 0) begin
      if (req0_valid && req1_valid) n.owner = 1 - s.lastw;
      else if (req0_valid)          n.owner = 0;
      else if (req1_valid)          n.owner = 1;
    end else begin
      tmo  = (s.idle == TMO - 1);
      done = (a0 && req0_last) || (a1 && req1_last) || ((a0 || a1) && (s.cnt + 1 == MAXP));
      n.cnt  = (a0 || a1) ? s.cnt + 1 : s.cnt;
      n.idle = (a0 || a1) ? 0 : s.idle + 1;
      if (tmo || done) begin
        n.owner = -1; n.lastw = s.owner; n.cnt = 0; n.idle = 0; n.tevt = tmo;
      end
    end
    if (a0)                 begin n.pv = 1'b1; n.pd = req0_data; end
    else if (a1)            begin n.pv = 1'b1; n.pd = req1_data; end
    else if (tx_data_ready) n.pv = 1'b0;
    return n;
  endfunction

  function automatic logic [13:0] m_out();
    logic [1:0] g;
    logic r0, r1;
    g  = (m.owner == 0) ? 2'b01 : (m.owner == 1) ? 2'b10 : 2'b00;
    r0 = (m.owner == 0) && (!m.pv || tx_data_ready);
    r1 = (m.owner == 1) && (!m.pv || tx_data_ready);
    return {g, r0, r1, m.pv, m.pd, m.tevt};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= m_reset();
    else          m <= m_next(m);
  end

  // Stimulus state
  typedef struct packed { logic [7:0] d; logic l; } byte_t;
  byte_t      q0[$], q1[$];
  logic [7:0] sent[$];
  logic [1:0] glist[$];
  logic [1:0] gprev;
  bit         acc0_f, acc1_f, gate0, gate1, txr_next;
  logic       cur_v0, cur_l0;
  logic [7:0] cur_d0;
  int         cyc = 0;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic [1:0] eg;
    logic       er0;
    logic       etv;
    logic [7:0] etd;
  } vec_t;
  vec_t tbl[6];

  task automatic cycle(input bit from_q);
    @(negedge clk);
    tx_data_ready = txr_next;
    if (from_q) begin
      if (acc0_f) q0.delete(0);
      if (acc1_f) q1.delete(0);
      req0_valid = gate0 && (q0.size() > 0);
      req0_data  = (q0.size() > 0) ? q0[0].d : 8'h00;
      req0_last  = (q0.size() > 0) ? q0[0].l : 1'b0;
      req1_valid = gate1 && (q1.size() > 0);
      req1_data  = (q1.size() > 0) ? q1[0].d : 8'h00;
      req1_last  = (q1.size() > 0) ? q1[0].l : 1'b0;
    end else begin
      req0_valid = cur_v0; req0_data = cur_d0; req0_last = cur_l0;
      req1_valid = 1'b0;   req1_data = 8'h00;  req1_last = 1'b0;
    end
    #2;
    cyc++;
    chk("outs", 32'({grant, req0_ready, req1_ready, tx_data_valid, tx_data, timeout_evt}), 32'(m_out()));
    acc0_f = req0_valid && req0_ready;
    acc1_f = req1_valid && req1_ready;
    if (tx_data_valid && tx_data_ready) sent.push_back(tx_data);
    if (grant != gprev) begin
      glist.push_back(grant);
      gprev = grant;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst outs", 32'({grant, req0_ready, req1_ready, tx_data_valid, tx_data, timeout_evt}), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0; req0_last = 1'b0; req1_last = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    q0.delete(); q1.delete(); sent.delete(); glist.delete();
    acc0_f = 1'b0; acc1_f = 1'b0; gate0 = 1'b1; gate1 = 1'b1;
    txr_next = 1'b1; tx_data_ready = 1'b1; gprev = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_sent(input string name, input int n, input int budget);
    int k = 0;
    while (sent.size() < n && k < budget) begin
      cycle(1'b1);
      k++;
    end
    chk({name, " reached"}, 32'(sent.size()), 32'(n));
  endtask

  task automatic check_sent(input string name, input logic [7:0] exp[$]);
    int nbad = 0;
    chk({name, " len"}, 32'(sent.size()), 32'(exp.size()));
    foreach (exp[i]) if (i >= sent.size() || sent[i] !== exp[i]) nbad++;
    chk({name, " bytes bad"}, 32'(nbad), 32'd0);
  endtask

  task automatic wait_acc0(input string name);
    int k = 0;
    do begin
      cycle(1'b1);
      k++;
    end while (!acc0_f && k < 10);
    chk({name, " accepted"}, 32'(acc0_f), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp[$];
    logic [1:0] gexp[$];
    int acc_cyc, k, nbad;

    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_last = 1'b0; req1_last = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00; tx_data_ready = 1'b1;
    cur_v0 = 1'b0; cur_d0 = 8'h00; cur_l0 = 1'b0;

    // 3-byte packet from req0 with the transmitter always ready, cycle by cycle from reset.
    tbl[0] = '{1'b1, 8'h41, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h41, 1'b0, 2'b01, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'h42, 1'b0, 2'b01, 1'b1, 1'b1, 8'h41};
    tbl[3] = '{1'b1, 8'h43, 1'b1, 2'b01, 1'b1, 1'b1, 8'h42};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 8'h43};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 8'h43};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      cur_v0 = tbl[i].v0; cur_d0 = tbl[i].d0; cur_l0 = tbl[i].l0;
      cycle(1'b0);
      chk($sformatf("vec%0d", i), 32'({grant, req0_ready, tx_data_valid, tx_data}),
          32'({tbl[i].eg, tbl[i].er0, tbl[i].etv, tbl[i].etd}));
    end

    // Tie after reset: req0 goes first, packets are not interleaved.
    do_reset();
    q0.push_back('{8'hA0, 1'b0}); q0.push_back('{8'hA1, 1'b1});
    q1.push_back('{8'hB0, 1'b0}); q1.push_back('{8'hB1, 1'b1});
    wait_sent("tie", 4, 40);
    exp = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
    check_sent("tie", exp);

    // Length limit: req1 streams 300 unterminated bytes, req0 slips in after byte 256.
    do_reset();
    for (int i = 0; i < 300; i++) q1.push_back('{8'(i), 1'b0});
    cycle(1'b1);
    cycle(1'b1);
    q0.push_back('{8'h10, 1'b0}); q0.push_back('{8'h11, 1'b1});
    wait_sent("maxlen", 302, 400);
    repeat (25) cycle(1'b1);
    exp.delete();
    for (int i = 0; i < 256; i++) exp.push_back(8'(i));
    exp.push_back(8'h10); exp.push_back(8'h11);
    for (int i = 256; i < 300; i++) exp.push_back(8'(i));
    check_sent("maxlen", exp);
    gexp = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    chk("maxlen grants len", 32'(glist.size()), 32'(gexp.size()));
    nbad = 0;
    foreach (gexp[i]) if (i >= glist.size() || glist[i] !== gexp[i]) nbad++;
    chk("maxlen grants bad", 32'(nbad), 32'd0);

    // Idle timeout: one byte then silence.
    do_reset();
    q0.push_back('{8'h33, 1'b0});
    wait_acc0("tmo");
    acc_cyc = cyc;
    k = 0;
    do begin
      cycle(1'b1);
      k++;
    end while (!timeout_evt && k < 40);
    // Acceptance edge ends cycle acc_cyc; the pulse follows the 16th edge after it, i.e. cycle acc_cyc+17.
    chk("tmo delay", 32'(cyc - acc_cyc), 32'd17);
    chk("tmo grant", 32'(grant), 32'd0);
    cycle(1'b1);
    chk("tmo pulse", 32'(timeout_evt), 32'd0);

    // Stalled transmitter: pending byte held, requester blocked.
    do_reset();
    txr_next = 1'b0;
    q0.push_back('{8'h5A, 1'b0}); q0.push_back('{8'h5B, 1'b1});
    wait_acc0("stall");
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1);
      chk($sformatf("stall%0d", i), 32'({tx_data, tx_data_valid, req0_ready}), 32'({8'h5A, 1'b1, 1'b0}));
    end
    txr_next = 1'b1;
    wait_sent("stall", 2, 60);
    exp = '{8'h5A, 8'h5B};
    check_sent("stall", exp);

    // Reset in the middle of a packet, then a fresh packet.
    do_reset();
    q0.push_back('{8'h61, 1'b0}); q0.push_back('{8'h62, 1'b0});
    q0.push_back('{8'h63, 1'b0}); q0.push_back('{8'h64, 1'b1});
    wait_sent("midrst", 2, 20);
    do_reset();
    q0.push_back('{8'h71, 1'b0}); q0.push_back('{8'h72, 1'b0}); q0.push_back('{8'h73, 1'b1});
    wait_sent("afterrst", 3, 30);
    exp = '{8'h71, 8'h72, 8'h73};
    check_sent("afterrst", exp);

    // Random traffic with quiet windows to provoke timeouts.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ((c % 500) < 460) begin
        if (q0.size() < 8 && $urandom_range(0, 3) == 0)
          q0.push_back('{8'($urandom), ($urandom_range(0, 3) == 0)});
        if (q1.size() < 8 && $urandom_range(0, 3) == 0)
          q1.push_back('{8'($urandom), ($urandom_range(0, 3) == 0)});
      end
      txr_next = ($urandom_range(0, 3) != 0);
      gate0    = ($urandom_range(0, 7) != 0);
      gate1    = ($urandom_range(0, 7) != 0);
      cycle(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
